// File: rtl/aref_scheduler.sv
// Periodic auto-refresh scheduler: forwards host instruction pairs to the two-slot
// dispatcher and, on each tREFI expiry, injects PRE-all / WAIT tRP / REF / WAIT tRFC.
module aref_scheduler #(
  parameter logic [9:0]  T_RP_CYC    = 10'd10,
  parameter logic [27:0] DEF_TRFC    = 28'd160,
  parameter int unsigned MAX_PENDING = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        aref_set_interval,
  input  logic [27:0] aref_interval,
  input  logic        aref_set_trfc,
  input  logic [27:0] aref_trfc,
  input  logic        host_hold,
  input  logic        host_en0,
  input  logic        host_en1,
  input  logic [31:0] host_instr0,
  input  logic [31:0] host_instr1,
  output logic        host_ack0,
  output logic        host_ack1,
  output logic        disp_en0,
  output logic        disp_en1,
  output logic [31:0] disp_instr0,
  output logic [31:0] disp_instr1,
  input  logic        disp_ack0,
  input  logic        disp_ack1,
  output logic        aref_busy,
  output logic [3:0]  aref_pending,
  output logic        aref_overflow,
  output logic [31:0] aref_count
);

  // Instruction layout: [31:28] type, [27] CKE, [26] CS_n, [25] RAS_n, [24] CAS_n,
  // [23] WE_n, [22:20] bank, [19:0] address (A10 = bit 10); WAIT count in [9:0].
  localparam logic [3:0]  OP_WAIT       = 4'b0001;
  localparam logic [3:0]  OP_DDR        = 4'b0100;
  localparam logic [31:0] PRE_ALL_INSTR = {OP_DDR, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 20'h00400};
  localparam logic [31:0] REF_INSTR     = {OP_DDR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 20'h00000};
  localparam logic [3:0]  MAX_PEND      = 4'(MAX_PENDING);

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_REF} state_t;

  state_t      state, state_next;
  logic        sent0, sent1, sent0_next, sent1_next;
  logic [27:0] interval_r, trfc_r, counter;
  logic [3:0]  pending, pending_next;
  logic        overflow_set;
  logic        wrap, done0, done1, seq_done, ref_done;
  logic [9:0]  trfc_wait, rp_wait;

  assign wrap = (interval_r != 28'd0) && !aref_set_interval &&
                (counter == interval_r - 28'd1);

  // Odd WAIT counts keep the dispatcher from swapping its slot sources.
  assign trfc_wait = ((trfc_r > 28'd1023) ? 10'h3FF : trfc_r[9:0]) | 10'd1;
  assign rp_wait   = T_RP_CYC | 10'd1;

  // A slot outside IDLE only drives en while unsent, so ack alone marks it done.
  assign done0    = sent0 | disp_ack0;
  assign done1    = sent1 | disp_ack1;
  assign seq_done = (state != ST_IDLE) && done0 && done1;
  assign ref_done = seq_done && (state == ST_REF);

  always_comb begin
    pending_next = pending;
    overflow_set = 1'b0;
    if (wrap && !ref_done) begin
      if (pending == MAX_PEND) overflow_set = 1'b1;
      else                     pending_next = pending + 4'd1;
    end else if (ref_done && !wrap) begin
      pending_next = pending - 4'd1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_next  = state;
    sent0_next  = sent0;
    sent1_next  = sent1;
    disp_en0    = 1'b0;
    disp_en1    = 1'b0;
    host_ack0   = 1'b0;
    host_ack1   = 1'b0;
    disp_instr0 = host_instr0;
    disp_instr1 = host_instr1;
    case (state)
      ST_IDLE: begin
        disp_en0  = host_en0;
        disp_en1  = host_en1;
        host_ack0 = host_en0 & disp_ack0;
        host_ack1 = host_en1 & disp_ack1;
        // Leave only at a pair boundary so a half-accepted host pair is never split.
        if ((pending != 4'd0) && !host_hold &&
            (!host_en0 || disp_ack0) && (!host_en1 || disp_ack1))
          state_next = ST_PRE;
      end
      ST_PRE, ST_REF: begin
        disp_en0    = ~sent0;
        disp_en1    = ~sent1;
        disp_instr0 = (state == ST_PRE) ? PRE_ALL_INSTR : REF_INSTR;
        disp_instr1 = {OP_WAIT, 18'd0, (state == ST_PRE) ? rp_wait : trfc_wait};
        if (seq_done) begin
          sent0_next = 1'b0;
          sent1_next = 1'b0;
          if (state == ST_PRE)
            state_next = ST_REF;
          else
            state_next = ((pending_next != 4'd0) && !host_hold) ? ST_PRE : ST_IDLE;
        end else begin
          sent0_next = done0;
          sent1_next = done1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (rst) begin
      disp_en0  = 1'b0;
      disp_en1  = 1'b0;
      host_ack0 = 1'b0;
      host_ack1 = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      sent0         <= 1'b0;
      sent1         <= 1'b0;
      interval_r    <= 28'd0;
      trfc_r        <= DEF_TRFC;
      counter       <= 28'd0;
      pending       <= 4'd0;
      aref_overflow <= 1'b0;
      aref_count    <= 32'd0;
    end else begin
      state   <= state_next;
      sent0   <= sent0_next;
      sent1   <= sent1_next;
      pending <= pending_next;
      if (overflow_set) aref_overflow <= 1'b1;
      if (ref_done)     aref_count    <= aref_count + 32'd1;
      if (aref_set_trfc) trfc_r <= aref_trfc;
      if (aref_set_interval) begin
        interval_r <= aref_interval;
        counter    <= 28'd0;
      end else if (interval_r != 28'd0) begin
        counter <= wrap ? 28'd0 : counter + 28'd1;
      end
    end
  end

  assign aref_busy    = (state != ST_IDLE);
  assign aref_pending = pending;

endmodule

// File: tb/tb_aref_scheduler.sv
// Bench for aref_scheduler: expected dispatcher slot traffic is queued by the stimulus
// and popped by an independent monitor whenever a slot handshake completes.
module tb_aref_scheduler;

  localparam logic [31:0] PRE_I  = 32'h4900_0400;
  localparam logic [31:0] REF_I  = 32'h4880_0000;
  localparam logic [31:0] W_RP   = 32'h1000_000B;
  localparam logic [31:0] W161   = 32'h1000_00A1;
  localparam logic [31:0] W1023  = 32'h1000_03FF;
  localparam logic [31:0] W201   = 32'h1000_00C9;

  logic        clk = 1'b0;
  logic        rst;
  logic        aref_set_interval, aref_set_trfc, host_hold;
  logic [27:0] aref_interval, aref_trfc;
  logic        host_en0, host_en1, host_ack0, host_ack1;
  logic [31:0] host_instr0, host_instr1, disp_instr0, disp_instr1;
  logic        disp_en0, disp_en1, disp_ack0, disp_ack1;
  logic        aref_busy, aref_overflow;
  logic [3:0]  aref_pending;
  logic [31:0] aref_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];

  aref_scheduler dut (
    .clk(clk), .rst(rst),
    .aref_set_interval(aref_set_interval), .aref_interval(aref_interval),
    .aref_set_trfc(aref_set_trfc), .aref_trfc(aref_trfc),
    .host_hold(host_hold),
    .host_en0(host_en0), .host_en1(host_en1),
    .host_instr0(host_instr0), .host_instr1(host_instr1),
    .host_ack0(host_ack0), .host_ack1(host_ack1),
    .disp_en0(disp_en0), .disp_en1(disp_en1),
    .disp_instr0(disp_instr0), .disp_instr1(disp_instr1),
    .disp_ack0(disp_ack0), .disp_ack1(disp_ack1),
    .aref_busy(aref_busy), .aref_pending(aref_pending),
    .aref_overflow(aref_overflow), .aref_count(aref_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_interval(input logic [27:0] v);
    aref_interval = v; aref_set_interval = 1'b1;
    cycles(1);
    aref_set_interval = 1'b0;
  endtask

  task automatic set_trfc(input logic [27:0] v);
    aref_trfc = v; aref_set_trfc = 1'b1;
    cycles(1);
    aref_set_trfc = 1'b0;
  endtask

  task automatic push_seq(input logic [31:0] w_rfc, input int n);
    for (int i = 0; i < n; i++) begin
      exp0.push_back(PRE_I); exp1.push_back(W_RP);
      exp0.push_back(REF_I); exp1.push_back(w_rfc);
    end
  endtask

  task automatic wait_pending(input logic [3:0] v, input int budget);
    int n; bit hit;
    n = 0; hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk); n++;
      if (aref_pending == v) hit = 1'b1;
    end
    check("wait_pending", 32'(hit), 32'd1);
    @(posedge clk); #1;
  endtask

  // Releases host_hold and counts busy cycles until the scheduler is idle and drained.
  task automatic drain(input int budget, output int nbusy);
    int n; bit seen, fin;
    n = 0; nbusy = 0; seen = 1'b0; fin = 1'b0;
    host_hold = 1'b0;
    while (!fin && n < budget) begin
      @(negedge clk); n++;
      if (aref_busy) begin nbusy++; seen = 1'b1; end
      else if (seen && aref_pending == 4'd0) fin = 1'b1;
    end
    check("drain_finished", 32'(fin), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic arm_one_refresh();
    host_hold = 1'b1;
    set_interval(28'd10);
    wait_pending(4'd1, 40);
    set_interval(28'd0);
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    bit d0, d1; int n;
    d0 = 1'b0; d1 = 1'b0; n = 0;
    exp0.push_back(a); exp1.push_back(b);
    host_instr0 = a; host_instr1 = b; host_en0 = 1'b1; host_en1 = 1'b1;
    while (!(d0 && d1) && n < 50) begin
      @(negedge clk);
      if (host_ack0) d0 = 1'b1;
      if (host_ack1) d1 = 1'b1;
      @(posedge clk); #1; n++;
      if (d0) host_en0 = 1'b0;
      if (d1) host_en1 = 1'b0;
    end
    check("host_pair_accepted", 32'({d0, d1}), 32'd3);
  endtask

  // Scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (disp_en0 && disp_ack0) begin
        if (exp0.size() == 0) begin
          total++; bad++;
          $display("FAIL slot0_unexpected actual=%h required=none t=%0t", disp_instr0, $time);
        end else check("slot0_instr", disp_instr0, exp0.pop_front());
      end
      if (disp_en1 && disp_ack1) begin
        if (exp1.size() == 0) begin
          total++; bad++;
          $display("FAIL slot1_unexpected actual=%h required=none t=%0t", disp_instr1, $time);
        end else check("slot1_instr", disp_instr1, exp1.pop_front());
      end
      if (aref_busy) check("no_host_ack_busy", 32'({host_ack0, host_ack1}), 32'd0);
      else           check("idle_passthrough_en", 32'({disp_en0, disp_en1}), 32'({host_en0, host_en1}));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    rst = 1'b1; aref_set_interval = 1'b0; aref_set_trfc = 1'b0;
    aref_interval = '0; aref_trfc = '0; host_hold = 1'b0;
    host_en0 = 1'b1; host_en1 = 1'b1; host_instr0 = 32'h1; host_instr1 = 32'h2;
    disp_ack0 = 1'b1; disp_ack1 = 1'b1;
    cycles(3);
    @(negedge clk);
    check("reset_disp_en", 32'({disp_en0, disp_en1}), 32'd0);
    check("reset_host_ack", 32'({host_ack0, host_ack1}), 32'd0);
    @(posedge clk); #1;
    host_en0 = 1'b0; host_en1 = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(aref_busy), 32'd0);
    check("reset_pending", 32'(aref_pending), 32'd0);
    check("reset_overflow", 32'(aref_overflow), 32'd0);
    check("reset_count", aref_count, 32'd0);
    @(posedge clk); #1;

    // Plain passthrough with refresh disabled.
    send_pair(32'hA000_0001, 32'hA000_0002);
    send_pair(32'hA000_0003, 32'hA000_0004);

    // Periodic refresh, interval 100.
    set_trfc(28'd160);
    push_seq(W161, 3);
    set_interval(28'd100);
    wait_pending(4'd1, 150);
    @(negedge clk);
    check("t1_pre_slot0", disp_instr0, PRE_I);
    check("t1_pre_slot1", disp_instr1, W_RP);
    @(negedge clk);
    check("t1_ref_slot0", disp_instr0, REF_I);
    check("t1_ref_slot1", disp_instr1, W161);
    cycles(210);
    check("t1_count", aref_count, 32'd3);
    check("t1_pending", 32'(aref_pending), 32'd0);
    set_interval(28'd0);

    // host_hold accumulates 5 refreshes, then back-to-back drain.
    host_hold = 1'b1;
    set_interval(28'd100);
    cycles(503);
    check("t2_pending", 32'(aref_pending), 32'd5);
    check("t2_no_inject", 32'(aref_busy), 32'd0);
    set_interval(28'd0);
    push_seq(W161, 5);
    drain(60, nb);
    check("t2_busy_cycles", 32'(nb), 32'd10);
    check("t2_count", aref_count, 32'd8);
    check("t2_overflow", 32'(aref_overflow), 32'd0);

    // Saturation at 8 with sticky overflow.
    host_hold = 1'b1;
    set_interval(28'd10);
    cycles(102);
    set_interval(28'd0);
    check("t3_pending_sat", 32'(aref_pending), 32'd8);
    check("t3_overflow", 32'(aref_overflow), 32'd1);
    push_seq(W161, 8);
    drain(60, nb);
    check("t3_busy_cycles", 32'(nb), 32'd16);
    check("t3_overflow_sticky", 32'(aref_overflow), 32'd1);
    check("t3_count", aref_count, 32'd16);

    // tRFC clamping and odd forcing.
    set_trfc(28'd2000);
    arm_one_refresh();
    push_seq(W1023, 1);
    drain(20, nb);
    set_trfc(28'd200);
    arm_one_refresh();
    push_seq(W201, 1);
    drain(20, nb);
    check("t5_count", aref_count, 32'd18);

    // Refresh due while the host pair is only half accepted.
    arm_one_refresh();
    exp0.push_back(32'hB000_0001); exp1.push_back(32'hB000_0002);
    push_seq(W201, 1);
    host_hold = 1'b0; disp_ack1 = 1'b0;
    host_instr0 = 32'hB000_0001; host_instr1 = 32'hB000_0002;
    host_en0 = 1'b1; host_en1 = 1'b1;
    @(negedge clk);
    check("t4_half_ack", 32'({host_ack0, host_ack1}), 32'd2);
    @(posedge clk); #1;
    host_en0 = 1'b0; disp_ack1 = 1'b1;
    @(negedge clk);
    check("t4_still_idle", 32'(aref_busy), 32'd0);
    check("t4_slot1_ack", 32'(host_ack1), 32'd1);
    @(posedge clk); #1;
    host_en1 = 1'b0;
    @(negedge clk);
    check("t4_injecting", 32'(aref_busy), 32'd1);
    @(posedge clk); #1;
    send_pair(32'hB000_0003, 32'hB000_0004);
    check("t4_count", aref_count, 32'd19);

    // Reset in REF with only slot0 sent.
    arm_one_refresh();
    exp0.push_back(PRE_I); exp1.push_back(W_RP); exp0.push_back(REF_I);
    host_hold = 1'b0;
    cycles(2);
    disp_ack1 = 1'b0;
    cycles(1);
    check("t6_ref_half_sent", 32'({aref_busy, disp_en0, disp_en1}), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_disp_en", 32'({disp_en0, disp_en1}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; disp_ack1 = 1'b1;
    @(negedge clk);
    check("t6_idle", 32'(aref_busy), 32'd0);
    check("t6_pending", 32'(aref_pending), 32'd0);
    check("t6_disp_en", 32'({disp_en0, disp_en1}), 32'd0);
    @(posedge clk); #1;
    send_pair(32'hC000_0001, 32'hC000_0002);

    cycles(3);
    check("exp0_drained", 32'(exp0.size()), 32'd0);
    check("exp1_drained", 32'(exp1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aref_scheduler.md
Name: aref_scheduler

Overview:
- Periodic auto-refresh scheduler. Sits between the host instruction slot pair and the two-slot instruction dispatcher.
- Forwards host instruction pairs unchanged in normal operation.
- At every tREFI expiry it blocks the host at a pair boundary and injects the PRE-all / WAIT tRP / REF / WAIT tRFC sequence into the two dispatcher slots.
- tREFI and tRFC are taken from the dispatcher's aref_set_interval / aref_set_trfc outputs.

Parameters:
- T_RP_CYC, 10, WAIT count issued after PRE-all (10-bit, forced odd).
- DEF_TRFC, 28'd160, tRFC value loaded at reset.
- MAX_PENDING, 8, saturation limit of postponed refreshes (at most 15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- aref_set_interval  in  1  load tREFI
- aref_interval  in  28  tREFI in clk cycles; 0 disables refresh
- aref_set_trfc  in  1  load tRFC
- aref_trfc  in  28  tRFC WAIT count
- host_hold  in  1  host forbids starting a refresh (e.g. during a timed test)
- host_en0 / host_en1  in  1  host slot valid
- host_instr0 / host_instr1  in  32  host slot instruction
- host_ack0 / host_ack1  out  1  host slot accepted
- disp_en0 / disp_en1  out  1  to dispatcher en_in0/1
- disp_instr0 / disp_instr1  out  32  to dispatcher instr_in0/1
- disp_ack0 / disp_ack1  in  1  from dispatcher en_ack0/1; meaningful only while the matching disp_en is high
- aref_busy  out  1  state != IDLE
- aref_pending  out  4  queued refreshes
- aref_overflow  out  1  sticky: a tREFI expired while aref_pending == MAX_PENDING
- aref_count  out  32  completed refreshes (wraps)

Behaviour:
- Reset: interval_r=0, trfc_r=DEF_TRFC, counter=0, pending=0, overflow=0, aref_count=0, state=IDLE, sent0=sent1=0. All disp_en and host_ack outputs are 0 during reset.
- Interval counter:
  - Loaded with 0 on aref_set_interval, which also stores interval_r.
  - With interval_r != 0, increments every cycle. When counter == interval_r-1 it wraps to 0 and pending increments.
  - If pending == MAX_PENDING at that point, pending holds and overflow is set.
  - With interval_r == 0 the counter holds at 0; existing pending entries still drain.
- Same-cycle wrap and completion: a wrap and a REF completion in the same cycle leave pending unchanged.
- tRFC load: aref_set_trfc stores trfc_r.
- WAIT counts:
  - tRFC WAIT = min(trfc_r, 1023) with bit0 forced to 1.
  - tRP WAIT = T_RP_CYC with bit0 forced to 1.
  - Odd counts mean the dispatcher never swaps its slot sources.
- Instruction encodings (softMC.inc macros):
  - PRE-all: DDR_INSTR, CS=0, RAS=0, CAS=1, WE=0, CKE=1, A10=1.
  - REF: DDR_INSTR, CS=0, RAS=0, CAS=0, WE=1, CKE=1.
  - WAIT: WAIT opcode with count in [9:0].
- IDLE:
  - disp_en/instr = host_en/instr; host_ack = disp_ack & host_en.
  - Pair boundary: each host_en is either low, or acked this cycle.
  - Goes to PRE at a pair boundary when pending != 0 and host_hold = 0.
  - Never leaves IDLE with one host slot acked and the other not, so host order is preserved.
- PRE:
  - host_ack0/1 = 0.
  - disp_en0 = ~sent0 with PRE-all; disp_en1 = ~sent1 with WAIT tRP.
  - sentN sets on disp_ackN while disp_enN is high.
  - When both slots are sent (including the same cycle): clear sent flags, go to REF.
- REF:
  - Same slot rules as PRE, with REF in slot0 and WAIT tRFC in slot1.
  - When both slots are sent: pending decrements, aref_count increments, sent flags clear.
  - Then goes to PRE if pending (after update) != 0 and host_hold = 0, otherwise IDLE.
- host_hold inside PRE/REF has no effect; an injected sequence always completes.
- Slot completion order: slot1 may be acked before slot0 (dispatcher ack order); completion requires both sent flags.
- rst mid-sequence: immediate return to IDLE. Partially issued sequences are abandoned; the DRAM must be re-initialised by software.
- No combinational path from host_* to disp_* outside IDLE.

Test Plan:
- Set aref_interval=100, trfc=160, host idle, dispatcher acks every cycle.
  - Expect: PRE-all + WAIT 11 one cycle after the wrap, then REF + WAIT 161 next cycle.
  - Sequence repeats every 100 cycles; aref_count=3 after 300 cycles.
- host_hold=1 for 500 cycles with interval=100.
  - Expect: pending climbs to 5 with no injection.
  - On release: 5 back-to-back PRE/REF pairs, then pending=0, aref_count=5.
- host_hold=1 with interval=10 for 100 cycles.
  - Expect: pending saturates at 8, aref_overflow=1, and it stays 1 after the drain.
- Refresh due while host streams pairs, dispatcher acks only slot0 on the first cycle.
  - Expect: scheduler stays in IDLE until host slot1 is acked, then injects.
  - Check: no host ack during PRE/REF; host instruction order is unchanged.
- trfc=2000.
  - Expect: WAIT count 1023.
  - trfc=200 → expect WAIT count 201.
- Assert rst while in REF with only slot0 sent.
  - Expect: next cycle IDLE, pending=0, disp_en=0, host passthrough resumes.
